// File: rtl/display_scan_controller_if.sv
// display_scan_controller_if
//   Groups the scan-control and display-drive signals of
//   display_scan_controller into one bundle.
//   master : drives enable / digit_mask, observes the scan outputs
//   slave  : the scan controller itself
//   enable      - scan enable; low pauses scanning with the display dark
//   digit_mask  - bit i = 1 includes digit i in the scan
//   digit_index - currently selected digit (to the segment-data mux)
//   anode       - one-hot digit drive to the display pins
//   slot_tick   - one-cycle pulse on the first cycle of every slot
//   frame_tick  - one-cycle pulse on the first cycle of the lowest enabled digit's slot
`timescale 1ns/1ps
interface display_scan_controller_if #(
  parameter int NUM_DIGITS = 8
);
  localparam int IW = ($clog2(NUM_DIGITS) < 1) ? 1 : $clog2(NUM_DIGITS);

  logic                  enable;
  logic [NUM_DIGITS-1:0] digit_mask;
  logic [IW-1:0]         digit_index;
  logic [NUM_DIGITS-1:0] anode;
  logic                  slot_tick;
  logic                  frame_tick;

  modport master (
    output enable,
    output digit_mask,
    input  digit_index,
    input  anode,
    input  slot_tick,
    input  frame_tick
  );

  modport slave (
    input  enable,
    input  digit_mask,
    output digit_index,
    output anode,
    output slot_tick,
    output frame_tick
  );
endinterface

// File: rtl/display_scan_controller.sv
// display_scan_controller
//   Time-multiplexing scan controller for seven-segment displays. Each digit
//   slot lasts PRESCALE clocks: BLANK_CYCLES dark (segment mux settles), then
//   the selected anode is lit for the remainder. Masked-off digits are skipped;
//   a fully masked display stays dark with the index held.
//   Ports:
//     clock - system clock (single domain)
//     reset - asynchronous, active-high reset
//     scan  - display_scan_controller_if.slave (enable, digit_mask in;
//             digit_index, anode, slot_tick, frame_tick out, all registered)
`timescale 1ns/1ps
module display_scan_controller #(
  parameter int NUM_DIGITS   = 8,
  parameter int PRESCALE     = 100000,
  parameter int BLANK_CYCLES = 16,
  parameter int ACTIVE_LOW   = 1
) (
  input  logic                         clock,
  input  logic                         reset,
  display_scan_controller_if.slave     scan
);
  localparam int IW = ($clog2(NUM_DIGITS) < 1) ? 1 : $clog2(NUM_DIGITS);
  localparam int CW = ($clog2(PRESCALE) < 1) ? 1 : $clog2(PRESCALE);

  localparam logic [CW-1:0]         CNT_LAST   = CW'(PRESCALE - 1);
  localparam logic [CW-1:0]         BLANK_LAST = CW'(BLANK_CYCLES - 1);
  localparam logic [NUM_DIGITS-1:0] ANODE_OFF  = (ACTIVE_LOW != 0) ? '1 : '0;
  localparam logic [NUM_DIGITS-1:0] ONE_HOT0   = NUM_DIGITS'(1);

  typedef enum logic [1:0] {
    IDLE,
    BLANK,
    DRIVE
  } state_t;

  state_t                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [NUM_DIGITS-1:0] anode_q, anode_d;
  logic [NUM_DIGITS-1:0] mask_q, mask_d;
  logic                  slot_q, slot_d;
  logic                  frame_q, frame_d;

  logic [IW-1:0]         next_idx;
  logic [IW-1:0]         lowest_idx;
  logic                  mask_any;

  // Next enabled digit strictly above cur, wrapping modulo NUM_DIGITS so an
  // index >= NUM_DIGITS is never produced. Returns cur itself when it is the
  // only enabled digit, and cur unchanged when nothing is enabled.
  function automatic logic [IW-1:0] next_enabled(input logic [IW-1:0] cur,
                                                 input logic [NUM_DIGITS-1:0] m);
    logic [IW-1:0] r;
    logic [IW-1:0] p;
    logic          found;
    int unsigned   pos;
    r     = cur;
    found = 1'b0;
    for (int unsigned i = 1; i <= NUM_DIGITS; i++) begin
      pos = 32'(cur) + i;
      if (pos >= NUM_DIGITS) pos = pos - NUM_DIGITS;
      p = IW'(pos);
      if (!found && m[p]) begin
        r     = p;
        found = 1'b1;
      end
    end
    return r;
  endfunction

  function automatic logic [IW-1:0] lowest_enabled(input logic [NUM_DIGITS-1:0] m);
    logic [IW-1:0] r;
    r = '0;
    for (int unsigned i = NUM_DIGITS; i > 0; i--) begin
      if (m[IW'(i - 1)]) r = IW'(i - 1);
    end
    return r;
  endfunction

  assign next_idx   = next_enabled(idx_q, scan.digit_mask);
  assign lowest_idx = lowest_enabled(scan.digit_mask);
  assign mask_any   = |scan.digit_mask;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    anode_d = ANODE_OFF;
    mask_d  = mask_q;
    slot_d  = 1'b0;
    frame_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (scan.enable) begin
          state_d = BLANK;
          mask_d  = scan.digit_mask;
          slot_d  = 1'b1;
          frame_d = mask_any && (idx_q == lowest_idx);
        end
      end

      BLANK, DRIVE: begin
        if (!scan.enable) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          // Slot boundary: the mask is captured here so that mid-slot edits
          // only affect the following slot. An all-zero mask holds the index
          // and suppresses the ticks while the slot counter keeps cycling.
          state_d = BLANK;
          cnt_d   = '0;
          mask_d  = scan.digit_mask;
          if (mask_any) begin
            idx_d   = next_idx;
            slot_d  = 1'b1;
            frame_d = (next_idx == lowest_idx);
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
          if (state_q == DRIVE) begin
            anode_d = anode_q;
          end else if (cnt_q == BLANK_LAST && mask_q[idx_q]) begin
            state_d = DRIVE;
            anode_d = (ACTIVE_LOW != 0) ? ~(ONE_HOT0 << idx_q) : (ONE_HOT0 << idx_q);
          end
        end
      end

      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      anode_q <= ANODE_OFF;
      mask_q  <= '0;
      slot_q  <= 1'b0;
      frame_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      anode_q <= anode_d;
      mask_q  <= mask_d;
      slot_q  <= slot_d;
      frame_q <= frame_d;
    end
  end

  assign scan.digit_index = idx_q;
  assign scan.anode       = anode_q;
  assign scan.slot_tick   = slot_q;
  assign scan.frame_tick  = frame_q;
endmodule

// File: tb/tb_display_scan_controller.sv
// tb_display_scan_controller
//   Bench for display_scan_controller with an 8-digit and a 6-digit instance
//   (PRESCALE=10, BLANK_CYCLES=2, active-low anodes). Expected per-cycle
//   {anode, index, slot_tick, frame_tick} records are queued when a scenario
//   is launched and popped one per clock as the DUT runs.
`timescale 1ns/1ps
module tb_display_scan_controller;
  logic clock;
  logic reset;

  display_scan_controller_if #(.NUM_DIGITS(8)) bus8 ();
  display_scan_controller_if #(.NUM_DIGITS(6)) bus6 ();

  display_scan_controller #(
    .NUM_DIGITS(8), .PRESCALE(10), .BLANK_CYCLES(2), .ACTIVE_LOW(1)
  ) u_dut8 (
    .clock(clock),
    .reset(reset),
    .scan (bus8)
  );

  display_scan_controller #(
    .NUM_DIGITS(6), .PRESCALE(10), .BLANK_CYCLES(2), .ACTIVE_LOW(1)
  ) u_dut6 (
    .clock(clock),
    .reset(reset),
    .scan (bus6)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct packed {
    logic [7:0] anode;
    logic [7:0] idx;
    logic       st;
    logic       ft;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Expected record for position pos (cnt) of a slot selecting digit idx.
  function automatic exp_t scan_rec(input int idx, input int pos, input bit frame);
    exp_t e;
    logic [7:0] one;
    one     = 8'h01;
    e.anode = (pos < 2) ? 8'hFF : ~(one << idx);
    e.idx   = 8'(idx);
    e.st    = (pos == 0);
    e.ft    = (pos == 0) && frame;
    return e;
  endfunction

  function automatic exp_t obs8();
    return {bus8.anode, 5'b0, bus8.digit_index, bus8.slot_tick, bus8.frame_tick};
  endfunction

  function automatic exp_t obs6();
    return {2'b11, bus6.anode, 5'b0, bus6.digit_index, bus6.slot_tick, bus6.frame_tick};
  endfunction

  // Holds reset for one edge, then releases it together with enable so the
  // next edge moves the 8-digit DUT from IDLE to BLANK.
  task automatic start8(input logic [7:0] m);
    reset        = 1'b1;
    bus8.enable  = 1'b0;
    bus6.enable  = 1'b0;
    tick();
    bus8.digit_mask = m;
    bus8.enable     = 1'b1;
    reset           = 1'b0;
  endtask

  task automatic test_reset();
    exp_t o;
    reset           = 1'b1;
    bus8.enable     = 1'b1;
    bus6.enable     = 1'b1;
    bus8.digit_mask = 8'hFF;
    bus6.digit_mask = 6'h3F;
    tick();
    tick();
    o = obs8();
    n_checks++;
    if (o !== {8'hFF, 8'h00, 2'b00}) begin
      n_fail++;
      $display("FAIL reset8 got %h expected %h", o, {8'hFF, 8'h00, 2'b00});
    end
    o = obs6();
    n_checks++;
    if (o !== {8'hFF, 8'h00, 2'b00}) begin
      n_fail++;
      $display("FAIL reset6 got %h expected %h", o, {8'hFF, 8'h00, 2'b00});
    end
  endtask

  task automatic test_full_scan();
    exp_t e, o;
    start8(8'hFF);
    for (int k = 0; k < 92; k++) exp_q.push_back(scan_rec((k / 10) % 8, k % 10, ((k / 10) % 8) == 0));
    for (int k = 0; k < 92; k++) begin
      tick();
      e = exp_q.pop_front();
      o = obs8();
      n_checks++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL full_scan k=%0d got %h expected %h", k, o, e);
      end
    end
  endtask

  task automatic test_six_digits();
    exp_t e, o;
    reset           = 1'b1;
    bus8.enable     = 1'b0;
    bus6.enable     = 1'b0;
    tick();
    bus6.digit_mask = 6'h3F;
    bus6.enable     = 1'b1;
    reset           = 1'b0;
    for (int k = 0; k < 72; k++) exp_q.push_back(scan_rec((k / 10) % 6, k % 10, ((k / 10) % 6) == 0));
    for (int k = 0; k < 72; k++) begin
      tick();
      e = exp_q.pop_front();
      o = obs6();
      n_checks++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL six_digits k=%0d got %h expected %h", k, o, e);
      end
    end
    bus6.enable = 1'b0;
  endtask

  task automatic test_sparse_mask();
    exp_t e, o;
    start8(8'b0000_0101);
    for (int k = 0; k < 45; k++) exp_q.push_back(scan_rec(((k / 10) % 2) * 2, k % 10, ((k / 10) % 2) == 0));
    for (int k = 0; k < 45; k++) begin
      tick();
      e = exp_q.pop_front();
      o = obs8();
      n_checks++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL sparse_mask k=%0d got %h expected %h", k, o, e);
      end
    end
  endtask

  task automatic test_zero_mask();
    exp_t e, o;
    start8(8'h00);
    exp_q.push_back({8'hFF, 8'd0, 1'b1, 1'b0});
    for (int k = 1; k < 30; k++) exp_q.push_back({8'hFF, 8'd0, 2'b00});
    for (int k = 30; k < 42; k++) exp_q.push_back(scan_rec(3, k % 10, 1'b1));
    for (int k = 0; k < 42; k++) begin
      tick();
      e = exp_q.pop_front();
      o = obs8();
      n_checks++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL zero_mask k=%0d got %h expected %h", k, o, e);
      end
      if (k == 23) bus8.digit_mask = 8'h08;
    end
  endtask

  task automatic test_enable_pause();
    exp_t e, o;
    start8(8'hFF);
    for (int k = 0; k < 46; k++) exp_q.push_back(scan_rec((k / 10) % 8, k % 10, ((k / 10) % 8) == 0));
    exp_q.push_back({8'hFF, 8'd4, 2'b00});
    exp_q.push_back({8'hFF, 8'd4, 2'b00});
    for (int p = 0; p < 10; p++) exp_q.push_back(scan_rec(4, p, 1'b0));
    for (int p = 0; p < 2; p++) exp_q.push_back(scan_rec(5, p, 1'b0));
    for (int k = 0; k < 60; k++) begin
      tick();
      e = exp_q.pop_front();
      o = obs8();
      n_checks++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL enable_pause k=%0d got %h expected %h", k, o, e);
      end
      if (k == 45) bus8.enable = 1'b0;
      if (k == 47) bus8.enable = 1'b1;
    end
  endtask

  task automatic test_async_reset();
    exp_t o;
    // Pulse during the first cycle of slot 1 (slot_tick high, index 1).
    start8(8'hFF);
    for (int k = 0; k <= 10; k++) tick();
    o = obs8();
    n_checks++;
    if (o !== {8'hFF, 8'd1, 2'b10}) begin
      n_fail++;
      $display("FAIL async_pre_tick got %h expected %h", o, {8'hFF, 8'd1, 2'b10});
    end
    #2 reset = 1'b1;
    #1;
    o = obs8();
    n_checks++;
    if (o !== {8'hFF, 8'd0, 2'b00}) begin
      n_fail++;
      $display("FAIL async_tick got %h expected %h", o, {8'hFF, 8'd0, 2'b00});
    end
    // Pulse mid-DRIVE of slot 1 (anode FD lit).
    start8(8'hFF);
    for (int k = 0; k <= 13; k++) tick();
    o = obs8();
    n_checks++;
    if (o !== {8'hFD, 8'd1, 2'b00}) begin
      n_fail++;
      $display("FAIL async_pre_drive got %h expected %h", o, {8'hFD, 8'd1, 2'b00});
    end
    #2 reset = 1'b1;
    #1;
    o = obs8();
    n_checks++;
    if (o !== {8'hFF, 8'd0, 2'b00}) begin
      n_fail++;
      $display("FAIL async_drive got %h expected %h", o, {8'hFF, 8'd0, 2'b00});
    end
    tick();
    reset = 1'b0;
  endtask

  initial begin
    reset           = 1'b1;
    bus8.enable     = 1'b0;
    bus6.enable     = 1'b0;
    bus8.digit_mask = 8'h00;
    bus6.digit_mask = 6'h00;
    test_reset();
    test_full_scan();
    test_six_digits();
    test_sparse_mask();
    test_zero_mask();
    test_enable_pause();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
